// File: rtl/quad_decoder_if.sv
// Encoder-side bundle for quad_decoder: raw A/B in, step/direction/error status out.
// Plain wires only; no flow control, the decoder never stalls the encoder.
interface quad_decoder_if;
    logic quad_a;
    logic quad_b;
    logic err_clr;
    logic step;
    logic up_count;
    logic err;
    logic err_sticky;
    logic tracking;

    modport master (
        output quad_a, quad_b, err_clr,
        input  step, up_count, err, err_sticky, tracking
    );

    modport slave (
        input  quad_a, quad_b, err_clr,
        output step, up_count, err, err_sticky, tracking
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync, per-channel glitch filter, Gray-code step/dir/err decode.
// Latency FILTER_LEN+2 edges from first s1 sample to step/err; no backpressure, one step per cycle max.
module quad_decoder #(
    parameter int FILTER_LEN = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    quad_decoder_if.slave  bus
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int IW = $clog2(FILTER_LEN + 3);

    typedef enum logic {ST_INIT = 1'b0, ST_TRACK = 1'b1} state_t;

    // Channel vectors are {A, B}; bit 1 is A, bit 0 is B.
    logic [1:0]    s1_q, s1_d;
    logic [1:0]    s2_q, s2_d;
    logic [1:0]    f_q, f_d;
    logic [CW-1:0] c_q [2];
    logic [CW-1:0] c_d [2];
    logic [1:0]    prev_q, prev_d;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    state_t        state_q, state_d;
    logic          step_q, step_d;
    logic          up_q, up_d;
    logic          err_q, err_d;
    logic          err_sticky_q, err_sticky_d;
    logic          tracking_q, tracking_d;

    // Position along the up sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] pos(input logic [1:0] ab);
        case (ab)
            2'b00:   pos = 2'd0;
            2'b10:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
    endfunction

    always_comb begin
        s1_d         = {bus.quad_a, bus.quad_b};
        s2_d         = s1_q;
        f_d          = f_q;
        c_d[0]       = c_q[0];
        c_d[1]       = c_q[1];
        prev_d       = f_q;
        init_cnt_d   = init_cnt_q;
        state_d      = state_q;
        step_d       = 1'b0;
        err_d        = 1'b0;
        up_d         = up_q;
        tracking_d   = tracking_q;
        // An error seen in the clear cycle (either detected now or still on the err pulse) beats the clear.
        err_sticky_d = (bus.err_clr && !err_q) ? 1'b0 : err_sticky_q;

        case (state_q)
            ST_INIT: begin
                f_d    = s2_q;
                c_d[0] = '0;
                c_d[1] = '0;
                if (init_cnt_q == IW'(FILTER_LEN + 2)) begin
                    state_d    = ST_TRACK;
                    tracking_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            default: begin
                for (int i = 0; i < 2; i++) begin
                    if (s2_q[i] == f_q[i]) begin
                        c_d[i] = '0;
                    end else if (c_q[i] == CW'(FILTER_LEN - 1)) begin
                        f_d[i] = s2_q[i];
                        c_d[i] = '0;
                    end else begin
                        c_d[i] = c_q[i] + CW'(1);
                    end
                end

                if ((f_q ^ prev_q) == 2'b11) begin
                    err_d        = 1'b1;
                    err_sticky_d = 1'b1;
                end else if (pos(f_q) == pos(prev_q) + 2'd1) begin
                    step_d = 1'b1;
                    up_d   = 1'b1;
                end else if (pos(prev_q) == pos(f_q) + 2'd1) begin
                    step_d = 1'b1;
                    up_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            f_q          <= '0;
            c_q[0]       <= '0;
            c_q[1]       <= '0;
            prev_q       <= '0;
            init_cnt_q   <= '0;
            state_q      <= ST_INIT;
            step_q       <= 1'b0;
            up_q         <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            tracking_q   <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            f_q          <= f_d;
            c_q[0]       <= c_d[0];
            c_q[1]       <= c_d[1];
            prev_q       <= prev_d;
            init_cnt_q   <= init_cnt_d;
            state_q      <= state_d;
            step_q       <= step_d;
            up_q         <= up_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            tracking_q   <= tracking_d;
        end
    end

    assign bus.step       = step_q;
    assign bus.up_count   = up_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.tracking   = tracking_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with FILTER_LEN=4: reset/INIT, up/down decode, glitch filter, illegal jumps, mid-run reset.
module tb_quad_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    quad_decoder_if bus();

    quad_decoder #(.FILTER_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic b);
        bus.quad_a = a;
        bus.quad_b = b;
    endtask

    // Runs n cycles, recording step/err activity; indices are 1-based edge counts.
    task automatic watch(input int n, output int steps, output int errs, output int first_step,
                         output int first_err, output logic first_up, output logic last_up);
        steps = 0; errs = 0; first_step = -1; first_err = -1; first_up = 1'b0; last_up = 1'b0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (bus.step) begin
                steps++;
                if (first_step < 0) begin
                    first_step = i;
                    first_up   = bus.up_count;
                end
                last_up = bus.up_count;
            end
            if (bus.err) begin
                errs++;
                if (first_err < 0) first_err = i;
            end
        end
    endtask

    task automatic init_at(input logic a, input logic b);
        rst_n = 1'b0;
        drive(a, b);
        bus.err_clr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        int s, e, fs, fe, s2, e2;
        logic fu, lu;
        drive(1'b1, 1'b1);
        bus.err_clr = 1'b0;
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.step, bus.up_count, bus.err, bus.err_sticky, bus.tracking} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000",
                     {bus.step, bus.up_count, bus.err, bus.err_sticky, bus.tracking});
        else passes++;
        rst_n = 1'b1;
        watch(6, s, e, fs, fe, fu, lu);
        checks++;
        if (bus.tracking !== 1'b0) $display("FAIL tracking_early: got %b expected 0", bus.tracking);
        else passes++;
        watch(1, s2, e2, fs, fe, fu, lu);
        s += s2; e += e2;
        checks++;
        if (bus.tracking !== 1'b1) $display("FAIL tracking_rise: got %b expected 1", bus.tracking);
        else passes++;
        watch(20, s2, e2, fs, fe, fu, lu);
        s += s2; e += e2;
        checks++;
        if (s !== 0 || e !== 0) $display("FAIL init_quiet: steps=%0d errs=%0d expected 0/0", s, e);
        else passes++;
    endtask

    task automatic test_up();
        logic [1:0] seq [4];
        int s, e, fs, fe;
        logic fu, lu;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        init_at(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(seq[i][1], seq[i][0]);
            watch(20, s, e, fs, fe, fu, lu);
            checks++;
            if (s !== 1 || fs !== 7 || fu !== 1'b1 || e !== 0)
                $display("FAIL up_step%0d: steps=%0d at=%0d up=%b errs=%0d expected 1/7/1/0", i, s, fs, fu, e);
            else passes++;
        end
    endtask

    task automatic test_down();
        logic [1:0] seq [4];
        int s, e, fs, fe;
        logic fu, lu;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            drive(seq[i][1], seq[i][0]);
            watch(20, s, e, fs, fe, fu, lu);
            checks++;
            if (s !== 1 || fs !== 7 || fu !== 1'b0 || e !== 0)
                $display("FAIL down_step%0d: steps=%0d at=%0d up=%b errs=%0d expected 1/7/0/0", i, s, fs, fu, e);
            else passes++;
        end
        watch(50, s, e, fs, fe, fu, lu);
        checks++;
        if (s !== 0 || bus.up_count !== 1'b0)
            $display("FAIL idle_hold: steps=%0d up=%b expected 0/0", s, bus.up_count);
        else passes++;
    endtask

    task automatic test_glitch();
        int s, e, fs, fe, s2, e2;
        logic fu, lu;
        drive(1'b1, 1'b0);
        watch(3, s, e, fs, fe, fu, lu);
        drive(1'b0, 1'b0);
        watch(20, s2, e2, fs, fe, fu, lu);
        checks++;
        if (s + s2 !== 0 || e + e2 !== 0)
            $display("FAIL glitch_3: steps=%0d errs=%0d expected 0/0", s + s2, e + e2);
        else passes++;
        drive(1'b1, 1'b0);
        watch(5, s, e, fs, fe, fu, lu);
        drive(1'b0, 1'b0);
        watch(20, s2, e2, fs, fe, fu, lu);
        checks++;
        if (s + s2 !== 2 || e + e2 !== 0 || fu !== 1'b1 || lu !== 1'b0)
            $display("FAIL glitch_5: steps=%0d errs=%0d first_up=%b last_up=%b expected 2/0/1/0",
                     s + s2, e + e2, fu, lu);
        else passes++;
    endtask

    task automatic test_illegal();
        int s, e, fs, fe;
        logic fu, lu;
        logic found;
        drive(1'b1, 1'b1);
        watch(20, s, e, fs, fe, fu, lu);
        checks++;
        if (e !== 1 || fe !== 7 || s !== 0 || bus.err_sticky !== 1'b1)
            $display("FAIL illegal_jump: errs=%0d at=%0d steps=%0d sticky=%b expected 1/7/0/1",
                     e, fe, s, bus.err_sticky);
        else passes++;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err_sticky !== 1'b0) $display("FAIL sticky_clear: got %b expected 0", bus.err_sticky);
        else passes++;

        drive(1'b0, 1'b0);
        found = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.err) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) $display("FAIL err_second: got no err pulse within 20 cycles, expected one");
        else passes++;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err_sticky !== 1'b1 || bus.err !== 1'b0)
            $display("FAIL set_beats_clear: sticky=%b err=%b expected 1/0", bus.err_sticky, bus.err);
        else passes++;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err_sticky !== 1'b0) $display("FAIL sticky_clear2: got %b expected 0", bus.err_sticky);
        else passes++;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        int s, e, fs, fe, s2, e2;
        logic fu, lu;
        drive(1'b1, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.step, bus.up_count, bus.err, bus.err_sticky, bus.tracking} !== 5'b0)
            $display("FAIL midreset_outputs: got %b expected 00000",
                     {bus.step, bus.up_count, bus.err, bus.err_sticky, bus.tracking});
        else passes++;
        repeat (2) tick();
        rst_n = 1'b1;
        watch(6, s, e, fs, fe, fu, lu);
        checks++;
        if (bus.tracking !== 1'b0) $display("FAIL midreset_init: got %b expected 0", bus.tracking);
        else passes++;
        watch(1, s2, e2, fs, fe, fu, lu);
        s += s2; e += e2;
        checks++;
        if (bus.tracking !== 1'b1) $display("FAIL midreset_track: got %b expected 1", bus.tracking);
        else passes++;
        watch(30, s2, e2, fs, fe, fu, lu);
        s += s2; e += e2;
        checks++;
        if (s !== 0 || e !== 0) $display("FAIL midreset_quiet: steps=%0d errs=%0d expected 0/0", s, e);
        else passes++;
    endtask

    initial begin
        bus.quad_a  = 1'b0;
        bus.quad_b  = 1'b0;
        bus.err_clr = 1'b0;
        test_reset();
        test_up();
        test_down();
        test_glitch();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Upstream front-end for the up/down position counter: decodes a two-channel quadrature encoder (A/B) into a one-cycle step pulse plus a direction level.
- Direction polarity matches the counter's `up_count` convention: 1 = up, 0 = down.
- The counter is enabled by `step`, so it advances exactly one count per valid encoder edge.
- The block also synchronises and glitch-filters the asynchronous A/B inputs and flags illegal Gray-code jumps.

Parameters:
- FILTER_LEN, 4, cycles a synchronised input must differ from its filtered value before the filtered value updates; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- quad_a  input  1  encoder channel A; asynchronous to clk
- quad_b  input  1  encoder channel B; asynchronous to clk
- err_clr  input  1  synchronous clear for err_sticky
- step  output  1  one-cycle pulse per valid quadrature transition
- up_count  output  1  direction of the most recent valid step (1 = up, 0 = down)
- err  output  1  one-cycle pulse on an illegal transition (both channels changed)
- err_sticky  output  1  latched error flag
- tracking  output  1  high once the INIT phase completes

Behaviour:
- Reset (rst_n low, asynchronous): all flops are 0, including the synchroniser flops, filter counters and state regs.
  - Outputs on reset: step=0, up_count=0, err=0, err_sticky=0, tracking=0.
  - FSM state on reset: INIT.
- Synchroniser: two flops per channel (s1 -> s2). No logic between the flops.
- Filter, per channel, with filtered value f and counter c of width max(1, clog2(FILTER_LEN)):
  - If s2 == f: c <= 0.
  - Else if c == FILTER_LEN-1: f <= s2 and c <= 0.
  - Else: c <= c+1.
  - Pulses shorter than FILTER_LEN cycles (after synchronisation) are fully rejected.
- FSM states:
  - INIT:
    - A counter runs for FILTER_LEN+3 cycles.
    - f <= s2 directly (filter bypassed) and prev <= {f_a,f_b} every cycle.
    - step and err are held at 0.
    - When the counter expires, go to TRACK and set tracking=1.
  - TRACK:
    - Normal filtering and decode. There is no exit except reset.
- Decode in TRACK compares cur={f_a,f_b} against prev; prev <= cur every cycle.
  - Up sequence: 00->10->11->01->00 (A leads B). Response: step<=1, up_count<=1.
  - Down sequence: the reverse order. Response: step<=1, up_count<=0.
  - cur == prev: step<=0, and up_count holds its value.
  - Both bits changed: err<=1, err_sticky<=1, step<=0, up_count holds.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: let edge N be the first edge at which s1 samples a new level, and the level is held for at least FILTER_LEN+1 cycles.
  - f updates at edge N+1+FILTER_LEN.
  - step (or err) is high for exactly the one cycle following edge N+2+FILTER_LEN.
- err_clr: clears err_sticky on the next edge.
  - If an error occurs in the same cycle as err_clr, set wins and err_sticky stays 1.
- Both channels filtered in the same cycle: counts as an illegal jump, even if the physical edges were separated by less than one filter window.
- Reset mid-operation: the block returns immediately to INIT with all outputs 0. No spurious step or err is produced on TRACK entry, whatever the A/B level at reset release.
- Step rate: at most one step per cycle. A legal encoder can only produce consecutive steps spaced at least FILTER_LEN cycles apart.

Test Plan:
1. Reset release with A=1, B=1 held, FILTER_LEN=4 -> tracking rises after 7 cycles; step=0 and err=0 throughout.
2. From 00, drive four up steps 00->10->11->01->00, each held 20 cycles -> exactly 4 step pulses, each 1 cycle wide, with up_count=1; each pulse occurs 6 edges after the input changes.
3. Reverse sequence 00->01->11->10->00 -> 4 step pulses with up_count=0. Then hold the inputs idle for 50 cycles -> up_count stays 0 and step=0.
4. Glitch rejection: pulse A high for 3 cycles (FILTER_LEN=4) -> no step, no err. Pulse A high for 5 cycles -> two steps, up then down.
5. Illegal jump: from 00, toggle A and B on the same edge to 11 -> one err pulse, err_sticky=1, no step. Assert err_clr for 1 cycle -> err_sticky=0 on the next edge. Repeat with err_clr asserted in the same cycle as err -> err_sticky stays 1.
6. Assert rst_n low mid-sequence (inputs at 10) for 2 cycles -> all outputs 0 immediately. The block re-enters INIT, and no step is produced after tracking reasserts.
